// File: rtl/splitmix_pkg.sv
// Shared constants, FSM encoding and output finaliser for the SplitMix64 lane generator.
package splitmix_pkg;

  localparam logic [63:0] GAMMA  = 64'h9E3779B97F4A7C15;
  localparam logic [63:0] MIX_C1 = 64'hBF58476D1CE4E5B9;
  localparam logic [63:0] MIX_C2 = 64'h94D049BB133111EB;

  localparam int unsigned SH1 = 30;
  localparam int unsigned SH2 = 27;
  localparam int unsigned SH3 = 31;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    RUN      = 2'd1,
    HOLD     = 2'd2
  } fsm_t;

  // Final xor-shift applied combinationally to the last stage register.
  function automatic logic [63:0] mix_final(input logic [63:0] z);
    return z ^ (z >> SH3);
  endfunction

endpackage

// File: rtl/splitmix_lane_pipe.sv
// One SplitMix64 lane: state register plus the three mixer stage registers.
module splitmix_lane_pipe #(
  parameter logic [63:0] GAMMA = splitmix_pkg::GAMMA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        issue,
  input  logic        advance,
  output logic [63:0] word
);
  import splitmix_pkg::*;

  logic [63:0] state;
  logic [63:0] s1;
  logic [63:0] s2;
  logic [63:0] s3;
  logic [63:0] state_next;
  logic [63:0] x1;
  logic [63:0] x2;

  // Step increment and the xor-shift terms feeding each multiplier.
  always_comb begin
    state_next = state + GAMMA;
    x1         = s1 ^ (s1 >> SH1);
    x2         = s2 ^ (s2 >> SH2);
  end

  // State and stage registers; seed load overrides any coincident issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
    end else if (load) begin
      state <= seed;
    end else if (advance) begin
      s2 <= x1 * MIX_C1;
      s3 <= x2 * MIX_C2;
      if (issue) begin
        state <= state_next;
        s1    <= state_next;
      end
    end
  end

  assign word = mix_final(s3);

endmodule

// File: rtl/splitmix_lanes.sv
// Multi-lane SplitMix64 generator with seed load, 3-stage mixer and valid/ready output.
// Optional build macro SPLITMIX_LANES_CNT_EN adds out_count (accepted output handshakes).
module splitmix_lanes #(
  parameter int unsigned LANES = 4,
  parameter logic [63:0] GAMMA = splitmix_pkg::GAMMA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seed_valid,
  input  logic [64*LANES-1:0]  seed,
  input  logic                 run,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [64*LANES-1:0]  out_data,
`ifdef SPLITMIX_LANES_CNT_EN
  output logic [31:0]          out_count,
`endif
  output logic                 seeded
);
  import splitmix_pkg::*;

  fsm_t fsm_q;
  fsm_t fsm_d;
  logic v1;
  logic v2;
  logic v3;
  logic advance;
  logic issue;

  // Shared control: pipeline advance, issue gating and FSM next state.
  always_comb begin
    advance = !v3 || out_ready;
    issue   = (fsm_q == RUN) && run && advance && !seed_valid;
    fsm_d   = fsm_q;
    case (fsm_q)
      UNSEEDED: if (seed_valid) fsm_d = RUN;
      RUN:      if (!run)       fsm_d = HOLD;
      HOLD:     if (run)        fsm_d = RUN;
      default:                  fsm_d = UNSEEDED;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) fsm_q <= UNSEEDED;
    else     fsm_q <= fsm_d;
  end

  // Stage valid bits; a seed load flushes every in-flight word.
  always_ff @(posedge clk) begin
    if (rst || seed_valid) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (advance) begin
      v1 <= issue;
      v2 <= v1;
      v3 <= v2;
    end
  end

  assign out_valid = v3;
  assign seeded    = (fsm_q != UNSEEDED);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    splitmix_lane_pipe #(
      .GAMMA (GAMMA)
    ) u_pipe (
      .clk     (clk),
      .rst     (rst),
      .load    (seed_valid),
      .seed    (seed[64*i +: 64]),
      .issue   (issue),
      .advance (advance),
      .word    (out_data[64*i +: 64])
    );
  end

`ifdef SPLITMIX_LANES_CNT_EN
  logic [31:0] cnt_q;

  // Accepted-handshake counter, cleared by reset or reseed, wraps silently.
  always_ff @(posedge clk) begin
    if (rst || seed_valid)      cnt_q <= '0;
    else if (v3 && out_ready)   cnt_q <= cnt_q + 32'd1;
  end

  assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_splitmix_lanes.sv
// Self-checking bench for splitmix_lanes: directed steps with a scoreboard of model vectors.
module tb_splitmix_lanes;

  localparam int unsigned LANES = 4;
  localparam int unsigned W     = 64 * LANES;
  localparam logic [63:0] G     = 64'h9E3779B97F4A7C15;

  logic         clk = 1'b0;
  logic         rst;
  logic         seed_valid;
  logic [W-1:0] seed;
  logic         run;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         seeded;
`ifdef SPLITMIX_LANES_CNT_EN
  logic [31:0]  out_count;
`endif

  int compared   = 0;
  int mismatched = 0;
  int accepted   = 0;
  logic [W-1:0] sb[$];

  splitmix_lanes #(
    .LANES (LANES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_valid (seed_valid),
    .seed       (seed),
    .run        (run),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
`ifdef SPLITMIX_LANES_CNT_EN
    .out_count  (out_count),
`endif
    .seeded     (seeded)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sm_mix(input logic [63:0] x);
    logic [63:0] z;
    z = x;
    z = (z ^ (z >> 30)) * 64'hBF58476D1CE4E5B9;
    z = (z ^ (z >> 27)) * 64'h94D049BB133111EB;
    return z ^ (z >> 31);
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference stream for a seed vector: expected output vectors in order.
  task automatic fill(input logic [W-1:0] sv);
    logic [63:0]  st[LANES];
    logic [W-1:0] v;
    sb.delete();
    for (int unsigned l = 0; l < LANES; l++) st[l] = sv[64*l +: 64];
    repeat (1500) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        st[l] = st[l] + G;
        v[64*l +: 64] = sm_mix(st[l]);
      end
      sb.push_back(v);
    end
  endtask

  // One clock: score any handshake taken at this edge, check stall stability.
  task automatic cycle();
    logic         pend_pop;
    logic         stalled;
    logic [W-1:0] held;
    pend_pop = (out_valid === 1'b1) && out_ready && !rst;
    stalled  = (out_valid === 1'b1) && !out_ready && !rst && !seed_valid;
    held     = out_data;
    if (pend_pop) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", out_data, 'x);
      end else begin
        chk("stream", out_data, sb.pop_front());
      end
      accepted++;
    end
    @(posedge clk);
    #1;
    if (stalled) begin
      chk("stall_hold", out_data, held);
      chk("stall_valid", W'(out_valid), W'(1));
    end
  endtask

  task automatic do_seed(input logic [W-1:0] sv);
    seed       = sv;
    seed_valid = 1'b1;
    cycle();
    seed_valid = 1'b0;
    fill(sv);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    chk("wait_valid", W'(out_valid), W'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] sv;
    logic [W-1:0] v;
    int n;

    rst = 1'b1; seed_valid = 1'b0; run = 1'b0; out_ready = 1'b1; seed = '0;
    repeat (2) cycle();
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_data", out_data, '0);
    chk("rst_seeded", W'(seeded), W'(0));

    // Unseeded: run alone must not issue.
    rst = 1'b0; run = 1'b1;
    repeat (5) cycle();
    chk("unseeded_idle", W'(out_valid), W'(0));

    // Seed 0 on all lanes, latency and known first outputs.
    do_seed('0);
    chk("seeded_set", W'(seeded), W'(1));
    cycle(); chk("lat_e1", W'(out_valid), W'(0));
    cycle(); chk("lat_e2", W'(out_valid), W'(0));
    cycle(); chk("lat_e3", W'(out_valid), W'(1));
    v = {LANES{64'hE220A8397B1DCDAF}}; chk("seed0_w0", out_data, v);
    cycle();
    v = {LANES{64'h6E789E6AA1B965F4}}; chk("seed0_w1", out_data, v);
    cycle();
    v = {LANES{64'h06C45D188009454F}}; chk("seed0_w2", out_data, v);

    // Distinct seeds 0..3, lane slices, then 1000 vectors.
    for (int unsigned l = 0; l < LANES; l++) sv[64*l +: 64] = 64'(l);
    do_seed(sv);
    wait_valid(10);
    for (int unsigned l = 0; l < LANES; l++)
      chk($sformatf("lane%0d_slice", l), W'(out_data[64*l +: 64]), W'(sm_mix(64'(l) + G)));
    accepted = 0; n = 0;
    while (accepted < 1000 && n < 1200) begin cycle(); n++; end
    chk("count_1000", W'(accepted), W'(1000));

    // Random backpressure, ~30% ready.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 9) < 3);
      cycle();
    end
    out_ready = 1'b1;

    // Reseed while a word is stalled.
    out_ready = 1'b0;
    wait_valid(10);
    for (int unsigned l = 0; l < LANES; l++) sv[64*l +: 64] = {$urandom, $urandom};
    do_seed(sv);
    chk("reseed_stall_flush", W'(out_valid), W'(0));
    out_ready = 1'b1;
    wait_valid(10);
    chk("reseed_stall_first", W'(out_data[63:0]), W'(sm_mix(sv[63:0] + G)));
    repeat (5) cycle();

    // Reseed coincident with an issue while flowing.
    for (int unsigned l = 0; l < LANES; l++) sv[64*l +: 64] = {$urandom, $urandom};
    do_seed(sv);
    chk("reseed_issue_flush", W'(out_valid), W'(0));
    wait_valid(10);
    chk("reseed_issue_first", W'(out_data[W-1 -: 64]), W'(sm_mix(sv[W-1 -: 64] + G)));
    repeat (5) cycle();

    // run toggling: two issues, drain, resume.
    for (int unsigned l = 0; l < LANES; l++) sv[64*l +: 64] = {$urandom, $urandom};
    do_seed(sv);
    accepted = 0;
    repeat (2) cycle();
    run = 1'b0;
    repeat (5) cycle();
    chk("hold_drained", W'(accepted), W'(2));
    chk("hold_idle", W'(out_valid), W'(0));
    run = 1'b1;
    repeat (30) cycle();
    chk("resume_flow", W'(accepted > 20), W'(1));

    // Reset mid-pipeline.
    rst = 1'b1;
    cycle();
    chk("midrst_valid", W'(out_valid), W'(0));
    chk("midrst_data", out_data, '0);
    chk("midrst_seeded", W'(seeded), W'(0));
    rst = 1'b0;
    sb.delete();
    repeat (4) cycle();
    chk("midrst_idle", W'(out_valid), W'(0));

`ifdef SPLITMIX_LANES_CNT_EN
    do_seed('0);
    accepted = 0; n = 0;
    while (accepted < 10 && n < 40) begin cycle(); n++; end
    chk("cnt_10", W'(out_count), W'(10));
    do_seed('0);
    chk("cnt_reseed", W'(out_count), W'(0));
    out_ready = 1'b0;
    wait_valid(10);
    force dut.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_q;
    chk("cnt_forced", W'(out_count), W'(32'hFFFFFFFF));
    out_ready = 1'b1;
    cycle();
    chk("cnt_wrap", W'(out_count), W'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/splitmix_lanes.md
Name: splitmix_lanes

Overview:
- Parametrised multi-lane SplitMix64 generator for the PRNG/ECC datapath, replacing the fixed 4-lane, 256-bit mixer.
- Adds the following over the fixed version:
  - LANES independent 64-bit SplitMix64 streams, each with its own internal state.
  - A seed-load port.
  - A 3-stage pipelined mixer.
  - A valid/ready output handshake with backpressure.
- Feeds the random-scalar and nonce consumers in the elliptic-curve datapath.

Parameters:
- LANES, 4, number of independent 64-bit streams; legal range 1..16.
- GAMMA, 64'h9E3779B97F4A7C15, per-step state increment, shared by all lanes.

Ports:
- clk, input, 1, single clock; all logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- seed_valid, input, 1, loads the seed into every lane state; always accepted, there is no ready signal.
- seed, input, 64*LANES, seed for lane i in bits [64*i+63:64*i].
- run, input, 1, level-sensitive; 1 allows new words to be generated.
- out_valid, output, 1, out_data holds LANES fresh words.
- out_ready, input, 1, consumer accepts the output when out_valid && out_ready.
- out_data, output, 64*LANES, lane i output in bits [64*i+63:64*i].
- seeded, output, 1, at least one seed has been loaded since reset.

Behaviour:
- Reset is synchronous and active-high: rst sampled high at a rising edge of clk resets the block; clk is the only clock.
- Reset values:
  - All lane states = 0.
  - All pipeline data and valid bits = 0.
  - out_valid = 0, out_data = 0, seeded = 0.
  - FSM = UNSEEDED.
- rst has priority over every other input, including a mid-pipeline operation; in-flight words are discarded.
- FSM:
  - UNSEEDED: no issue. seed_valid moves to RUN.
  - RUN: issue happens when run && advance. run=0 moves to HOLD.
  - HOLD: no issue, pipeline keeps draining. run=1 moves to RUN. seed_valid is still accepted.
  - seeded = (FSM != UNSEEDED).
- Seed load: on a seed_valid edge, state[i] <= seed[i], all pipeline valids are cleared, and out_valid goes to 0 on the next cycle. This flushes stale words, including a word being stalled by out_ready=0.
- seed_valid in the same cycle as an issue: seed wins, no issue occurs, and the state takes the seed value rather than the incremented value.
- Pipeline advance rule: advance = !out_valid || out_ready. The whole pipeline moves as one unit and there are no bubbles-collapse requirements.
- Pipeline stages, per lane, with all arithmetic mod 2^64 and products truncated to the low 64 bits:
  - Issue: state <= state+GAMMA and S1 <= state+GAMMA.
  - S2 <= (S1 ^ (S1>>30)) * 64'hBF58476D1CE4E5B9.
  - S3 <= (S2 ^ (S2>>27)) * 64'h94D049BB133111EB.
  - out_data = S3 ^ (S3>>31), combinational from the S3 register.
  - out_valid = S3 valid bit.
- Latency: an issue at edge t gives out_valid=1 after edge t+2, i.e. 3 cycles counted inclusively. Throughput is 1 vector per cycle while run=1 and out_ready=1.
- Stall: while out_valid && !out_ready, out_data and all stage registers hold, and state does not advance.
- Lanes share control and are fully independent in data. Each lane is bit-exact to reference SplitMix64 for its seed.
- Wrap-around: the state wraps mod 2^64 silently; there is no flag.

Optional Feature:
- Macro: SPLITMIX_LANES_CNT_EN.
- Defined: adds output port out_count, 32 bits, which counts accepted output handshakes (out_valid && out_ready).
  - Cleared by rst and by seed_valid.
  - Wraps 0xFFFFFFFF -> 0.
  - Value after edge = number of vectors accepted so far.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package splitmix_pkg holds:
  - GAMMA, MIX_C1 = 64'hBF58476D1CE4E5B9, MIX_C2 = 64'h94D049BB133111EB.
  - Shift constants 30/27/31.
  - FSM enum {UNSEEDED, RUN, HOLD}.
- One sub-module, splitmix_lane_pipe: a single lane holding the state register and S1..S3 registers, with inputs load/issue/advance.
  - The top level holds the FSM, valid bits and handshake.
  - The top level instantiates LANES copies with a generate loop.

Test Plan:
- Reset, seed=0 on all lanes, run=1, out_ready=1:
  - Lane outputs are 0xE220A8397B1DCDAF, then 0x6E789E6AA1B965F4, then 0x06C45D188009454F, on consecutive cycles.
  - First out_valid appears 3 cycles after the first issue.
- LANES=4 with distinct seeds 0,1,2,3: each lane matches an independent software SplitMix64 model for 1000 vectors, with a lane-i to bit-slice check.
- Random out_ready backpressure at 30% high:
  - out_data is stable while stalled.
  - No vector is lost or duplicated against the model sequence.
- Reseed while stalled (out_valid=1, out_ready=0):
  - out_valid=0 on the next cycle.
  - The next valid word equals the first output of the new seed.
  - Repeat with seed_valid coincident with an issue.
- run toggling: run=0 for 5 cycles after 2 issues.
  - 2 words drain, then out_valid=0.
  - After resume the sequence continues with no skip.
  - rst asserted mid-pipeline returns all outputs to 0 and seeded to 0.
- With SPLITMIX_LANES_CNT_EN defined:
  - out_count = 10 after 10 accepted vectors.
  - A reseed clears out_count to 0.
  - Forcing the count to 0xFFFFFFFF, one accept wraps it to 0.
